psram_spi_responder: RTL

- Synthesizable single-bit SPI PSRAM device model: the responder end of the serial link driven by the team's PSRAM controller.
- Decodes an 8-bit command and a 24-bit address, then streams bytes out of, or into, an internal memory array with auto-incrementing address.
- Used as the DUT-side partner in controller benches and as an on-FPGA loopback stand-in when no PSRAM chip is fitted.
- A backdoor port lets benches preload and inspect memory.

---
 rtl/psram_spi_responder.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/psram_spi_responder.sv
// Single-bit SPI PSRAM responder: decodes an opcode and address, then streams
// bytes out of, or into, an internal byte array. A backdoor port gives benches direct access.
module psram_spi_responder #(
    parameter int         MEM_ADDR_WIDTH = 12,
    parameter int         DATA_WIDTH     = 8,
    parameter int         ADDR_BITS      = 24,
    parameter logic [7:0] READ_CMD       = 8'hD0,
    parameter logic [7:0] WRITE_CMD      = 8'h40,
    parameter int         WAIT_CYCLES    = 0
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      chip_enable_n,
    input  logic                      serial_in,
    output logic                      serial_out,
    input  logic                      bd_we,
    input  logic [MEM_ADDR_WIDTH-1:0] bd_addr,
    input  logic [DATA_WIDTH-1:0]     bd_wdata,
    output logic [DATA_WIDTH-1:0]     bd_rdata,
    output logic                      bd_ready,
    output logic                      cmd_error,
    output logic                      txn_done
);
    localparam int CNT_W     = $clog2(ADDR_BITS + DATA_WIDTH + 16);
    localparam int DEPTH     = 1 << MEM_ADDR_WIDTH;
    localparam int WAIT_LOAD = (WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_ADDR,
        S_WAIT,
        S_READ,
        S_WRITE,
        S_IGNORE
    } state_t;

    state_t                    state_q;
    logic [6:0]                opcode_q;
    logic [CNT_W-1:0]          bit_cnt_q;
    logic [MEM_ADDR_WIDTH-1:0] addr_ptr_q;
    logic [DATA_WIDTH-1:0]     shift_q;
    logic                      is_write_q;
    logic                      serial_out_q;
    logic                      cmd_error_q;
    logic                      txn_done_q;

    logic [DATA_WIDTH-1:0]     mem [DEPTH];

    logic [7:0]                opcode_d;
    logic [MEM_ADDR_WIDTH-1:0] addr_d;
    logic [MEM_ADDR_WIDTH-1:0] addr_inc_d;
    logic [MEM_ADDR_WIDTH-1:0] rd_addr_d;
    logic [DATA_WIDTH-1:0]     rd_byte_d;
    logic [DATA_WIDTH-1:0]     wbyte_d;
    logic                      selected;
    logic                      last_bit;
    logic                      mem_we;
    logic                      bd_we_ok;

    // Values as they will be once the bit on serial_in is shifted in this edge.
    assign opcode_d   = {opcode_q, serial_in};
    assign addr_d     = {addr_ptr_q[MEM_ADDR_WIDTH-2:0], serial_in};
    assign wbyte_d    = {shift_q[DATA_WIDTH-2:0], serial_in};
    assign addr_inc_d = addr_ptr_q + MEM_ADDR_WIDTH'(1);
    assign selected   = !chip_enable_n;
    assign last_bit   = (bit_cnt_q == '0);

    // One read port: the byte about to be launched comes from the address just
    // completed (ADDR), the held pointer (WAIT) or the next byte (READ).
    assign rd_addr_d = (state_q == S_ADDR) ? addr_d :
                       (state_q == S_READ) ? addr_inc_d : addr_ptr_q;
    assign rd_byte_d = mem[rd_addr_d];

    assign mem_we   = !reset && selected && (state_q == S_WRITE) && last_bit;
    assign bd_we_ok = bd_we && (state_q == S_IDLE);

    // NOTE: the array has no reset branch; contents survive reset and it maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[addr_ptr_q] <= wbyte_d;
        end else if (bd_we_ok) begin
            mem[bd_addr] <= bd_wdata;
        end
    end

    assign bd_rdata = mem[bd_addr];

    // NOTE: all state updates below use non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            opcode_q     <= '0;
            bit_cnt_q    <= '0;
            addr_ptr_q   <= '0;
            shift_q      <= '0;
            is_write_q   <= 1'b0;
            serial_out_q <= 1'b0;
            cmd_error_q  <= 1'b0;
            txn_done_q   <= 1'b0;
        end else begin
            cmd_error_q <= 1'b0;
            txn_done_q  <= 1'b0;
            if (!selected) begin
                if (state_q != S_IDLE) begin
                    txn_done_q   <= (state_q == S_READ) || (state_q == S_WRITE) ||
                                    (state_q == S_WAIT);
                    state_q      <= S_IDLE;
                    serial_out_q <= 1'b0;
                    bit_cnt_q    <= '0;
                    shift_q      <= '0;
                    opcode_q     <= '0;
                end
            end else begin
                case (state_q)
                    S_IDLE: begin
                        opcode_q  <= {6'b0, serial_in};
                        bit_cnt_q <= CNT_W'(6);
                        state_q   <= S_CMD;
                    end
                    S_CMD: begin
                        opcode_q <= opcode_d[6:0];
                        if (last_bit) begin
                            if (opcode_d == READ_CMD || opcode_d == WRITE_CMD) begin
                                is_write_q <= (opcode_d == WRITE_CMD);
                                bit_cnt_q  <= CNT_W'(ADDR_BITS - 1);
                                state_q    <= S_ADDR;
                            end else begin
                                cmd_error_q <= 1'b1;
                                state_q     <= S_IGNORE;
                            end
                        end else begin
                            bit_cnt_q <= bit_cnt_q - CNT_W'(1);
                        end
                    end
                    S_ADDR: begin
                        // Only the low bits survive the shift; upper address bits fall off the top.
                        addr_ptr_q <= addr_d;
                        if (last_bit) begin
                            if (is_write_q) begin
                                bit_cnt_q <= CNT_W'(DATA_WIDTH - 1);
                                state_q   <= S_WRITE;
                            end else if (WAIT_CYCLES == 0) begin
                                shift_q      <= rd_byte_d;
                                serial_out_q <= rd_byte_d[DATA_WIDTH-1];
                                bit_cnt_q    <= CNT_W'(DATA_WIDTH - 1);
                                state_q      <= S_READ;
                            end else begin
                                bit_cnt_q <= CNT_W'(WAIT_LOAD);
                                state_q   <= S_WAIT;
                            end
                        end else begin
                            bit_cnt_q <= bit_cnt_q - CNT_W'(1);
                        end
                    end
                    S_WAIT: begin
                        if (last_bit) begin
                            shift_q      <= rd_byte_d;
                            serial_out_q <= rd_byte_d[DATA_WIDTH-1];
                            bit_cnt_q    <= CNT_W'(DATA_WIDTH - 1);
                            state_q      <= S_READ;
                        end else begin
                            bit_cnt_q <= bit_cnt_q - CNT_W'(1);
                        end
                    end
                    S_READ: begin
                        // bit_cnt_q indexes the bit currently on the wire.
                        if (last_bit) begin
                            addr_ptr_q   <= addr_inc_d;
                            shift_q      <= rd_byte_d;
                            serial_out_q <= rd_byte_d[DATA_WIDTH-1];
                            bit_cnt_q    <= CNT_W'(DATA_WIDTH - 1);
                        end else begin
                            shift_q      <= shift_q << 1;
                            serial_out_q <= shift_q[DATA_WIDTH-2];
                            bit_cnt_q    <= bit_cnt_q - CNT_W'(1);
                        end
                    end
                    S_WRITE: begin
                        if (last_bit) begin
                            addr_ptr_q <= addr_inc_d;
                            shift_q    <= '0;
                            bit_cnt_q  <= CNT_W'(DATA_WIDTH - 1);
                        end else begin
                            shift_q   <= wbyte_d;
                            bit_cnt_q <= bit_cnt_q - CNT_W'(1);
                        end
                    end
                    S_IGNORE: begin
                        serial_out_q <= 1'b0;
                    end
                    default: begin
                        state_q <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign serial_out = serial_out_q;
    assign cmd_error  = cmd_error_q;
    assign txn_done   = txn_done_q;
    assign bd_ready   = (state_q == S_IDLE);

endmodule
